// File: rtl/ate_stream_binarizer.sv
// Streaming adaptive-threshold binarizer: buffers each block in a ping-pong bank, derives a
// midrange or mean threshold from it, then replays the block with one binary decision per pixel.
module ate_stream_binarizer #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned BLK_LOG2 = 6,
  parameter int unsigned BPL_W    = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] pix_data,
  input  logic              mode,
  input  logic [BPL_W-1:0]  blocks_per_line,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_pix,
  output logic              bin,
  output logic [DATA_W-1:0] threshold,
  output logic              out_edge,
  output logic              blk_done
);

  localparam int unsigned BlkSize = 1 << BLK_LOG2;
  localparam int unsigned SumW    = DATA_W + BLK_LOG2;

  typedef enum logic [0:0] {StIdle, StReplay} state_e;

  // Write-side state
  logic [BLK_LOG2-1:0] k_q, k_d;
  logic [BPL_W-1:0]    b_q, b_d;
  logic [BPL_W-1:0]    n_q, n_d;
  logic                wsel_q, wsel_d;
  logic                mode_q, mode_d;
  logic [DATA_W-1:0]   max_q, max_d;
  logic [DATA_W-1:0]   min_q, min_d;
  logic [SumW-1:0]     sum_q, sum_d;
  logic [DATA_W-1:0]   thr_q, thr_d;
  logic                edge_q, edge_d;

  // Replay-side state
  state_e              state_q, state_d;
  logic [BLK_LOG2-1:0] r_q, r_d;

  // Registered outputs
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_pix_q, out_pix_d;
  logic              bin_q, bin_d;
  logic [DATA_W-1:0] threshold_q, threshold_d;
  logic              out_edge_q, out_edge_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] bank_q [2*BlkSize];

  logic              first_pix;
  logic              complete;
  logic              edge_now;
  logic              last_blk;
  logic [DATA_W:0]   mid_sum;
  logic [SumW-1:0]   mean_sum;
  logic [DATA_W-1:0] blk_thr;
  logic [DATA_W-1:0] rd_pix;
  logic              unused_bits;

  assign first_pix = (k_q == '0);
  assign complete  = in_valid && (k_q == '1);
  assign last_blk  = (b_q == n_q - 1'b1);
  assign edge_now  = (b_q == '0) || last_blk;

  // Running statistics, including the pixel accepted this cycle.
  always_comb begin
    max_d  = max_q;
    min_d  = min_q;
    sum_d  = sum_q;
    k_d    = k_q;
    mode_d = mode_q;
    n_d    = n_q;
    if (in_valid) begin
      k_d = k_q + 1'b1;
      if (first_pix) begin
        max_d  = pix_data;
        min_d  = pix_data;
        sum_d  = SumW'(pix_data);
        mode_d = mode;
        if (b_q == '0) begin
          n_d = (blocks_per_line == '0) ? BPL_W'(1) : blocks_per_line;
        end
      end else begin
        if (pix_data > max_q) max_d = pix_data;
        if (pix_data < min_q) min_d = pix_data;
        sum_d = sum_q + SumW'(pix_data);
      end
    end
  end

  assign mid_sum     = {1'b0, max_d} + {1'b0, min_d} + {{DATA_W{1'b0}}, 1'b1};
  assign mean_sum    = sum_d + SumW'(BlkSize / 2);
  assign blk_thr     = mode_q ? mean_sum[SumW-1:BLK_LOG2] : mid_sum[DATA_W:1];
  assign unused_bits = ^{mid_sum[0], mean_sum[BLK_LOG2-1:0]};

  always_comb begin
    thr_d  = thr_q;
    edge_d = edge_q;
    wsel_d = wsel_q;
    b_d    = b_q;
    done_d = 1'b0;
    if (complete) begin
      thr_d  = edge_now ? '0 : blk_thr;
      edge_d = edge_now;
      wsel_d = ~wsel_q;
      b_d    = last_blk ? '0 : b_q + 1'b1;
      done_d = 1'b1;
    end
  end

  // The completed bank is always the one not being written.
  assign rd_pix = bank_q[{~wsel_q, r_q}];

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    out_valid_d = 1'b0;
    out_pix_d   = '0;
    bin_d       = 1'b0;
    threshold_d = '0;
    out_edge_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
      end
      StReplay: begin
        out_valid_d = 1'b1;
        out_pix_d   = rd_pix;
        threshold_d = thr_q;
        out_edge_d  = edge_q;
        bin_d       = !edge_q && (rd_pix >= thr_q);
        r_d         = r_q + 1'b1;
        if (r_q == '1) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // A completion can coincide with the last read of the previous replay.
    if (complete) begin
      state_d = StReplay;
      r_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid) bank_q[{wsel_q, k_q}] <= pix_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q         <= '0;
      b_q         <= '0;
      n_q         <= '0;
      wsel_q      <= 1'b0;
      mode_q      <= 1'b0;
      max_q       <= '0;
      min_q       <= '0;
      sum_q       <= '0;
      thr_q       <= '0;
      edge_q      <= 1'b0;
      state_q     <= StIdle;
      r_q         <= '0;
      out_valid_q <= 1'b0;
      out_pix_q   <= '0;
      bin_q       <= 1'b0;
      threshold_q <= '0;
      out_edge_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      k_q         <= k_d;
      b_q         <= b_d;
      n_q         <= n_d;
      wsel_q      <= wsel_d;
      mode_q      <= mode_d;
      max_q       <= max_d;
      min_q       <= min_d;
      sum_q       <= sum_d;
      thr_q       <= thr_d;
      edge_q      <= edge_d;
      state_q     <= state_d;
      r_q         <= r_d;
      out_valid_q <= out_valid_d;
      out_pix_q   <= out_pix_d;
      bin_q       <= bin_d;
      threshold_q <= threshold_d;
      out_edge_q  <= out_edge_d;
      done_q      <= done_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pix   = out_pix_q;
  assign bin       = bin_q;
  assign threshold = threshold_q;
  assign out_edge  = out_edge_q;
  assign blk_done  = done_q;

endmodule

// File: tb/tb_ate_stream_binarizer.sv
// Bench for ate_stream_binarizer: directed block vectors, reset and throughput sequences, and
// randomized traffic checked cycle by cycle against a block-list reference model.
module tb_ate_stream_binarizer;

  localparam int MaxC = 16384;

  logic       clk = 1'b0;
  logic       rst, in_valid, mode;
  logic [7:0] pix_data;
  logic [6:0] blocks_per_line;
  logic       out_valid, bin, out_edge, blk_done;
  logic [7:0] out_pix, threshold;

  always #5 clk = ~clk;

  ate_stream_binarizer #(.DATA_W(8), .BLK_LOG2(2), .BPL_W(7)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .pix_data        (pix_data),
    .mode            (mode),
    .blocks_per_line (blocks_per_line),
    .out_valid       (out_valid),
    .out_pix         (out_pix),
    .bin             (bin),
    .threshold       (threshold),
    .out_edge        (out_edge),
    .blk_done        (blk_done)
  );

  typedef struct packed {
    logic [6:0]  bpl;
    logic        mode;
    logic        gaps;
    logic [2:0]  pos;
    logic [31:0] px;   // pixel i in px[8*i +: 8]
    logic [7:0]  thr;
    logic [3:0]  bin;  // MSB is pixel 0
    logic        edg;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Expected outputs per cycle
  logic       e_v    [MaxC];
  logic [7:0] e_pix  [MaxC];
  logic       e_bin  [MaxC];
  logic [7:0] e_thr  [MaxC];
  logic       e_edge [MaxC];
  logic       e_done [MaxC];

  // Reference model state
  int   m_b, m_n, m_cnt;
  logic m_mode;
  int   m_blk [4];

  int         cap_cyc  [$];
  logic [7:0] cap_pix  [$];
  logic [7:0] cap_thr  [$];
  logic       cap_bin  [$];
  logic       cap_edge [$];
  int         done_cyc [$];

  function automatic void check(input string name, input logic [63:0] got,
                                input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", name, got, want);
    end
  endfunction

  function automatic void clear_after(input int c0);
    for (int c = c0 + 1; c <= c0 + 8 && c < MaxC; c++) begin
      e_v[c] = 0; e_pix[c] = 0; e_bin[c] = 0; e_thr[c] = 0; e_edge[c] = 0; e_done[c] = 0;
    end
  endfunction

  function automatic void model_cycle(input logic v, input logic [7:0] p, input logic m,
                                      input logic [6:0] n, input logic r);
    int mx, mn, sm, thr, c;
    bit ed;
    if (r) begin
      clear_after(cyc);
      m_b = 0;
      m_cnt = 0;
      return;
    end
    if (!v) return;
    if (m_cnt == 0) begin
      m_mode = m;
      if (m_b == 0) m_n = (n == 0) ? 1 : int'(n);
    end
    m_blk[m_cnt] = int'(p);
    m_cnt++;
    if (m_cnt == 4) begin
      mx = 0; mn = 255; sm = 0;
      for (int i = 0; i < 4; i++) begin
        if (m_blk[i] > mx) mx = m_blk[i];
        if (m_blk[i] < mn) mn = m_blk[i];
        sm += m_blk[i];
      end
      ed  = (m_b == 0) || (m_b == m_n - 1);
      thr = ed ? 0 : (m_mode ? (sm + 2) / 4 : (mx + mn + 1) / 2);
      if (cyc + 6 < MaxC) begin
        e_done[cyc + 1] = 1;
        for (int i = 0; i < 4; i++) begin
          c = cyc + 2 + i;
          e_v[c] = 1; e_pix[c] = 8'(m_blk[i]); e_thr[c] = 8'(thr); e_edge[c] = ed;
          e_bin[c] = !ed && (m_blk[i] >= thr);
        end
      end
      m_b = (m_b == m_n - 1) ? 0 : m_b + 1;
      m_cnt = 0;
    end
  endfunction

  task automatic step(input logic v, input logic [7:0] p, input logic m, input logic [6:0] n,
                      input logic r);
    logic [19:0] got, want;
    in_valid = v; pix_data = p; mode = m; blocks_per_line = n; rst = r;
    model_cycle(v, p, m, n, r);
    @(posedge clk);
    #1;
    cyc++;
    got  = {out_valid, out_pix, bin, threshold, out_edge, blk_done};
    want = {e_v[cyc], e_pix[cyc], e_bin[cyc], e_thr[cyc], e_edge[cyc], e_done[cyc]};
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL cycle %0d {v,pix,bin,thr,edge,done} got=%0h required=%0h", cyc, got, want);
    end
    if (out_valid === 1'b1) begin
      cap_cyc.push_back(cyc); cap_pix.push_back(out_pix); cap_thr.push_back(threshold);
      cap_bin.push_back(bin); cap_edge.push_back(out_edge);
    end
    if (blk_done === 1'b1) done_cyc.push_back(cyc);
  endtask

  task automatic clear_caps();
    cap_cyc.delete(); cap_pix.delete(); cap_thr.delete(); cap_bin.delete();
    cap_edge.delete(); done_cyc.delete();
  endtask

  task automatic do_reset();
    step(1'b0, 8'd0, 1'b0, 7'd3, 1'b1);
    step(1'b0, 8'd0, 1'b0, 7'd3, 1'b1);
    clear_caps();
  endtask

  task automatic idle(input int cnt, input logic [6:0] n);
    for (int i = 0; i < cnt; i++) step(1'b0, 8'd0, 1'b0, n, 1'b0);
  endtask

  task automatic feed_block(input logic [31:0] px, input logic m, input logic [6:0] n,
                            input logic gaps, output int last_acc);
    last_acc = 0;
    for (int i = 0; i < 4; i++) begin
      last_acc = cyc;
      step(1'b1, px[8*i +: 8], m, n, 1'b0);
      if (gaps) step(1'b0, 8'hAA, m, n, 1'b0);
    end
  endtask

  function automatic vec_t mk(input int bpl, input bit md, input bit gp, input int pos,
                              input int a, input int b, input int c, input int d,
                              input int thr, input logic [3:0] bn, input bit ed);
    vec_t t;
    t.bpl = 7'(bpl); t.mode = md; t.gaps = gp; t.pos = 3'(pos);
    t.px = {8'(d), 8'(c), 8'(b), 8'(a)};
    t.thr = 8'(thr); t.bin = bn; t.edg = ed;
    return t;
  endfunction

  task automatic run_vec(input vec_t t, input int id);
    int acc, base;
    logic [31:0] gpx;
    logic [3:0]  gbin;
    logic [31:0] filler;
    filler = {8'd8, 8'd7, 8'd6, 8'd5};
    do_reset();
    acc = 0;
    for (int j = 0; j <= int'(t.pos); j++) begin
      feed_block((j == int'(t.pos)) ? t.px : filler, t.mode, t.bpl, t.gaps, acc);
    end
    idle(8, t.bpl);
    base = 4 * int'(t.pos);
    check($sformatf("vec%0d_count", id), 64'(cap_cyc.size()), 64'(base + 4));
    if (cap_cyc.size() == base + 4) begin
      for (int i = 0; i < 4; i++) begin
        gbin[3-i] = cap_bin[base+i];
        gpx[8*i +: 8] = cap_pix[base+i];
      end
      check($sformatf("vec%0d_result", id), {cap_thr[base], cap_edge[base], gbin, gpx},
            {t.thr, t.edg, t.bin, t.px});
      check($sformatf("vec%0d_latency", id), 64'(cap_cyc[base+3] - cap_cyc[base]) << 8 |
            64'(cap_cyc[base] - acc), (64'd3 << 8) | 64'd2);
    end
  endtask

  vec_t vecs [15];

  initial begin
    int acc;
    int ok;
    logic [6:0] n;
    logic md, v, r;
    logic [31:0] px;
    for (int c = 0; c < MaxC; c++) begin
      e_v[c] = 0; e_pix[c] = 0; e_bin[c] = 0; e_thr[c] = 0; e_edge[c] = 0; e_done[c] = 0;
    end
    m_b = 0; m_n = 1; m_cnt = 0; m_mode = 0;

    vecs[0]  = mk(3, 0, 0, 0,   1,   2,   3,   4,   0, 4'b0000, 1);
    vecs[1]  = mk(3, 0, 0, 1,  10,  20,  30,  41,  26, 4'b0011, 0);
    vecs[2]  = mk(3, 0, 0, 2,   0,   0,   0,   0,   0, 4'b0000, 1);
    vecs[3]  = mk(3, 1, 0, 1,  10,  11,  11,  11,  11, 4'b0111, 0);
    vecs[4]  = mk(3, 0, 0, 1,  10,  11,  11,  11,  11, 4'b0111, 0);
    vecs[5]  = mk(3, 0, 1, 1,  10,  20,  30,  41,  26, 4'b0011, 0);
    vecs[6]  = mk(3, 1, 1, 1,  10,  11,  11,  11,  11, 4'b0111, 0);
    vecs[7]  = mk(1, 0, 0, 0,  10,  20,  30,  41,   0, 4'b0000, 1);
    vecs[8]  = mk(1, 0, 0, 2,  10,  20,  30,  41,   0, 4'b0000, 1);
    vecs[9]  = mk(0, 1, 0, 1,  10,  20,  30,  41,   0, 4'b0000, 1);
    vecs[10] = mk(3, 0, 0, 1, 255, 255, 255, 255, 255, 4'b1111, 0);
    vecs[11] = mk(3, 1, 0, 1, 255, 255, 255, 255, 255, 4'b1111, 0);
    vecs[12] = mk(3, 0, 0, 1,   0,   0,   0,   0,   0, 4'b1111, 0);
    vecs[13] = mk(4, 1, 0, 2, 200, 100,  50,   3,  88, 4'b1100, 0);
    vecs[14] = mk(4, 0, 0, 3, 200, 100,  50,   3,   0, 4'b0000, 1);

    do_reset();
    check("reset_outputs", {out_valid, out_pix, bin, threshold, out_edge, blk_done}, 64'd0);

    for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

    // Reset during the 2nd pixel of a block while the previous block is replaying.
    do_reset();
    feed_block({8'd4, 8'd3, 8'd2, 8'd1}, 1'b0, 7'd3, 1'b0, acc);
    step(1'b1, 8'd10, 1'b0, 7'd3, 1'b0);
    step(1'b1, 8'd20, 1'b0, 7'd3, 1'b1);
    check("rst_mid_block_outputs", {out_valid, out_pix, bin, threshold, out_edge, blk_done},
          64'd0);
    clear_caps();
    feed_block({8'd41, 8'd30, 8'd20, 8'd10}, 1'b0, 7'd3, 1'b0, acc);
    feed_block({8'd41, 8'd30, 8'd20, 8'd10}, 1'b0, 7'd3, 1'b0, acc);
    idle(8, 7'd3);
    check("rst_block_count", 64'(cap_cyc.size()), 64'd8);
    if (cap_cyc.size() == 8) begin
      check("rst_first_is_edge", {cap_edge[0], cap_thr[0], cap_pix[0]}, {1'b1, 8'd0, 8'd10});
      check("rst_second_thr", {cap_edge[4], cap_thr[4], cap_bin[4], cap_bin[5], cap_bin[6],
            cap_bin[7]}, {1'b0, 8'd26, 4'b0011});
    end

    // Reset in the middle of a replay; nothing stale may appear afterwards.
    do_reset();
    feed_block({8'd4, 8'd3, 8'd2, 8'd1}, 1'b0, 7'd3, 1'b0, acc);
    feed_block({8'd41, 8'd30, 8'd20, 8'd10}, 1'b0, 7'd3, 1'b0, acc);
    idle(2, 7'd3);
    step(1'b0, 8'd0, 1'b0, 7'd3, 1'b1);
    check("rst_mid_replay_outputs", {out_valid, out_pix, bin, threshold, out_edge, blk_done},
          64'd0);
    clear_caps();
    idle(8, 7'd3);
    check("rst_no_stale_replay", 64'(cap_cyc.size()) << 8 | 64'(done_cyc.size()), 64'd0);

    // Back-to-back blocks, one full line of six.
    do_reset();
    for (int j = 0; j < 6; j++) begin
      px = $urandom;
      feed_block(px, 1'($urandom), 7'd6, 1'b0, acc);
    end
    idle(8, 7'd6);
    check("b2b_done_count", 64'(done_cyc.size()), 64'd6);
    if (done_cyc.size() == 6) begin
      ok = 1;
      for (int j = 1; j < 6; j++) if (done_cyc[j] - done_cyc[j-1] != 4) ok = 0;
      check("b2b_done_spacing", 64'(ok), 64'd1);
    end
    check("b2b_valid_count", 64'(cap_cyc.size()), 64'd24);
    if (cap_cyc.size() == 24) check("b2b_valid_span", 64'(cap_cyc[23] - cap_cyc[0]), 64'd23);

    // Randomized traffic with gaps, mode/bpl changes and occasional resets.
    for (int seg = 0; seg < 4; seg++) begin
      do_reset();
      n  = 7'($urandom_range(0, 5));
      md = 1'($urandom);
      for (int i = 0; i < 500; i++) begin
        if ($urandom_range(0, 49) == 0) md = ~md;
        if ($urandom_range(0, 99) == 0) n = 7'($urandom_range(0, 5));
        r = ($urandom_range(0, 199) == 0);
        v = ($urandom_range(0, 3) != 0);
        step(v, 8'($urandom), md, n, r);
      end
      idle(8, n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
